posit_encode_seq: RTL and testbench

POSIT_ENCODE_SEQ -- requirements
Module: posit_encode_seq

---
 rtl/posit_encode_seq_pkg.sv | 32 +++
 rtl/posit_encode_seq_if.sv | 28 ++
 rtl/posit_encode_seq_round.sv | 23 ++
 rtl/posit_encode_seq.sv | 152 +++++++++++++++
 tb/tb_posit_encode_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/posit_encode_seq_pkg.sv
// Shared types and helpers for the sequential posit encoder: FSM states,
// width helper and the special posit codes for a given word width.
package posit_encode_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Special codes are returned right-aligned in 64 bits; callers cast to N.
    function automatic logic [63:0] f_maxpos(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] f_minpos(input int n);
        return (n > 0) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] f_nar(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/posit_encode_seq_if.sv
// Request/result bundle between a client and the posit encoder.
interface posit_encode_seq_if #(
    parameter int N  = 16,
    parameter int es = 3
);
    localparam int Bs = posit_encode_seq_pkg::f_clog2(N);

    logic              start;
    logic              sign;
    logic [es+Bs:0]    scale;
    logic [N-2:0]      frac;
    logic              in_zero;
    logic              in_inf;
    logic [N-1:0]      out;
    logic              busy;
    logic              done;

    modport master (
        output start, sign, scale, frac, in_zero, in_inf,
        input  out, busy, done
    );

    modport slave (
        input  start, sign, scale, frac, in_zero, in_inf,
        output out, busy, done
    );

endinterface

// File: rtl/posit_encode_seq_round.sv
// Round-to-nearest-even of the posit body, clamped below NaR, then two's
// complement negation for negative values. Purely combinational.
module posit_rne_round #(
    parameter int N = 16
) (
    input  logic [N-2:0] i_body,
    input  logic         i_g,
    input  logic         i_st,
    input  logic         i_sign,
    output logic [N-1:0] o_word
);

    logic         w_ulp;
    logic [N-2:0] w_sum;
    logic [N-1:0] w_mag;

    assign w_ulp = i_g & (i_body[0] | i_st);
    // An all-ones body stays at maxpos instead of wrapping into NaR.
    assign w_sum = (&i_body) ? i_body : i_body + {{(N-2){1'b0}}, w_ulp};
    assign w_mag = {1'b0, w_sum};
    assign o_word = i_sign ? -w_mag : w_mag;

endmodule

// File: rtl/posit_encode_seq.sv
// Sequential posit encoder: regime is built by shifting a fill bit into a
// work register one position per cycle, then the body is rounded and signed.
module posit_encode_seq
    import posit_encode_seq_pkg::*;
#(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic              clk,
    input  logic              rst,
    posit_encode_seq_if.slave enc
);

    localparam int Bs = f_clog2(N);
    localparam int SW = es + Bs + 1;
    localparam int WW = 2 * N + es;
    localparam int CW = Bs + 1;
    localparam logic [N-1:0] NAR         = N'(f_nar(N));
    localparam logic [N-2:0] MAXPOS_BODY = (N-1)'(f_maxpos(N));
    localparam logic [N-2:0] MINPOS_BODY = (N-1)'(f_minpos(N));

    state_t        r_state;
    state_t        w_next;
    logic [WW-1:0] r_w;
    logic [CW-1:0] r_cnt;
    logic          r_fill;
    logic          r_sign;
    logic          r_inf;
    logic          r_zero;
    logic          r_sat_hi;
    logic          r_sat_lo;
    logic [N-1:0]  r_out;
    logic          r_busy;
    logic          r_done;

    logic [CW-1:0]        w_k_u;
    logic signed [CW-1:0] w_k;
    logic [es-1:0]        w_e;
    logic                 w_fill;
    logic [CW-1:0]        w_m;
    logic                 w_sat_hi;
    logic                 w_sat_lo;

    // Upper scale bits are exactly scale >>> es.
    assign w_k_u    = enc.scale[SW-1:es];
    assign w_k      = $signed(w_k_u);
    assign w_e      = enc.scale[es-1:0];
    assign w_fill   = ~w_k_u[CW-1];
    assign w_m      = w_fill ? (w_k_u + 1'b1) : (~w_k_u + 1'b1);
    assign w_sat_hi = (w_k >= $signed(CW'(N - 2)));
    assign w_sat_lo = (w_k <= $signed(CW'(1 - N)));

    logic [N-2:0] w_body;
    logic         w_g;
    logic         w_st;
    logic [N-1:0] w_rnd;
    logic [N-1:0] w_word;

    always_comb begin
        w_body = r_w[WW-1 -: N-1];
        w_g    = r_w[WW-N];
        w_st   = |r_w[WW-N-1:0];
        if (r_sat_hi) begin
            w_body = MAXPOS_BODY;
            w_g    = 1'b0;
            w_st   = 1'b0;
        end else if (r_sat_lo) begin
            w_body = MINPOS_BODY;
            w_g    = 1'b0;
            w_st   = 1'b0;
        end
    end

    posit_rne_round #(.N(N)) u_round (
        .i_body (w_body),
        .i_g    (w_g),
        .i_st   (w_st),
        .i_sign (r_sign),
        .o_word (w_rnd)
    );

    assign w_word = r_inf ? NAR : (r_zero ? '0 : w_rnd);

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enc.start) w_next = (enc.in_inf || enc.in_zero) ? S_ROUND : S_SHIFT;
            S_SHIFT: if (r_cnt == CW'(1)) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state updates use <= so every flop samples pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: W and cnt are plain flops, reset with everything else so an aborted operation leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w      <= '0;
            r_cnt    <= '0;
            r_fill   <= 1'b0;
            r_sign   <= 1'b0;
            r_inf    <= 1'b0;
            r_zero   <= 1'b0;
            r_sat_hi <= 1'b0;
            r_sat_lo <= 1'b0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enc.start) begin
                        r_w      <= {~w_fill, w_e, enc.frac, {N{1'b0}}};
                        r_cnt    <= w_m;
                        r_fill   <= w_fill;
                        r_sign   <= enc.sign;
                        r_inf    <= enc.in_inf;
                        r_zero   <= enc.in_zero;
                        r_sat_hi <= w_sat_hi;
                        r_sat_lo <= w_sat_lo;
                        r_busy   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_w   <= {r_fill, r_w[WW-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_ROUND: begin
                    r_out  <= w_word;
                    r_done <= 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign enc.out  = r_out;
    assign enc.busy = r_busy;
    assign enc.done = r_done;

endmodule

// File: tb/tb_posit_encode_seq.sv
// Directed bench for posit_encode_seq (N=16, es=3) with a bit-string posit
// model and a per-cycle monitor of busy/done/out.
module tb_posit_encode_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    posit_encode_seq_if #(.N(16), .es(3)) enc ();

    posit_encode_seq #(.N(16), .es(3)) dut (
        .clk (clk),
        .rst (rst),
        .enc (enc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: write the posit as a bit string (regime run, terminator,
    // exponent, fraction), keep the top 15 bits and round the rest away.
    function automatic void model(input logic sgn, input logic [7:0] sc, input logic [14:0] fr,
                                  input logic z, input logic inf,
                                  output logic [15:0] w, output int lat);
        int s, k, e, m, len;
        longint unsigned bits, regime, rem;
        logic [14:0] body;
        logic g, st;
        logic [15:0] mag;
        s   = int'($signed(sc));
        k   = (s >= 0) ? s / 8 : -((-s + 7) / 8);
        e   = s - 8 * k;
        m   = (k >= 0) ? k + 1 : -k;
        lat = (inf || z) ? 2 : m + 2;
        w   = 16'h0000;
        if (inf) begin
            w = 16'h8000;
            return;
        end
        if (z) return;
        if (k >= 14) mag = 16'h7FFF;
        else if (k <= -15) mag = 16'h0001;
        else begin
            regime = (k >= 0) ? (((64'd1 << m) - 64'd1) << 1) : 64'd1;
            bits   = (regime << 18) | (64'(e) << 15) | 64'(fr);
            len    = m + 1 + 18;
            body   = 15'(bits >> (len - 15));
            rem    = bits & ((64'd1 << (len - 15)) - 64'd1);
            g      = ((rem >> (len - 16)) & 64'd1) != 64'd0;
            st     = (rem & ((64'd1 << (len - 16)) - 64'd1)) != 64'd0;
            if (g && (body[0] || st) && body != 15'h7FFF) body = body + 15'd1;
            mag = {1'b0, body};
        end
        w = sgn ? -mag : mag;
    endfunction

    // Monitor handshake: the stimulus side only writes arm/abort/expected,
    // the monitor only writes its own progress counters.
    int          arm_seq = 0;
    int          abort_seq = 0;
    logic [15:0] exp_out = '0;
    int          exp_lat = 0;
    int          arm_seen = 0;
    int          abort_seen = 0;
    int          fin_seq = 0;
    bit          mon_on = 1'b0;
    int          mon_i = 0;

    // Sample i is taken at the i-th falling edge after the accept edge.
    always @(negedge clk) begin
        if (abort_seq != abort_seen) begin
            abort_seen = abort_seq;
            mon_on = 1'b0;
        end else begin
            if (!mon_on && arm_seq != arm_seen) begin
                arm_seen = arm_seq;
                mon_on = 1'b1;
                mon_i = 0;
            end
            if (mon_on) begin
                mon_i++;
                if (mon_i < exp_lat) begin
                    check("busy_while_working", enc.busy, 1);
                    check("done_early", enc.done, 0);
                end else if (mon_i == exp_lat) begin
                    check("done_pulse", enc.done, 1);
                    check("busy_at_done", enc.busy, 1);
                    check("out_at_done", enc.out, exp_out);
                end else begin
                    check("done_fall", enc.done, 0);
                    check("busy_fall", enc.busy, 0);
                    check("out_hold", enc.out, exp_out);
                    mon_on = 1'b0;
                    fin_seq++;
                end
            end
        end
    end

    task automatic run_op(input string name, input logic sgn, input logic [7:0] sc,
                          input logic [14:0] fr, input logic z, input logic inf,
                          input logic [15:0] lit, input int lit_lat, input bit hold);
        logic [15:0] m_out;
        int m_lat, f0;
        model(sgn, sc, fr, z, inf, m_out, m_lat);
        check({name, "_model"}, m_out, lit);
        check({name, "_model_lat"}, m_lat, lit_lat);
        @(negedge clk);
        enc.sign = sgn;
        enc.scale = sc;
        enc.frac = fr;
        enc.in_zero = z;
        enc.in_inf = inf;
        enc.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) enc.start = 1'b0;
        exp_out = m_out;
        exp_lat = m_lat;
        f0 = fin_seq;
        arm_seq++;
        if (hold) begin
            @(negedge clk);
            enc.sign = ~sgn;
            enc.scale = ~sc;
            enc.frac = ~fr;
            enc.in_zero = ~z;
            enc.in_inf = ~inf;
        end
        for (int c = 0; c < 64 && fin_seq == f0; c++) begin
            @(posedge clk);
            #1;
            if (enc.done) enc.start = 1'b0;
        end
        check({name, "_finished"}, fin_seq - f0, 1);
        check({name, "_lit"}, enc.out, lit);
        enc.start = 1'b0;
        enc.in_zero = 1'b0;
        enc.in_inf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] r_out;
        int r_lat;
        enc.start = 1'b0;
        enc.sign = 1'b0;
        enc.scale = '0;
        enc.frac = '0;
        enc.in_zero = 1'b0;
        enc.in_inf = 1'b0;
        #12;
        check("reset_busy", enc.busy, 0);
        check("reset_done", enc.done, 0);
        check("reset_out", enc.out, 0);
        #10;
        rst = 1'b0;

        //     name           sgn   scale   frac      zero  inf   literal   lat hold
        run_op("unit",        1'b0, 8'h00, 15'h0000, 1'b0, 1'b0, 16'h4000, 3,  1'b0);
        run_op("neg_scale",   1'b0, 8'hFF, 15'h0000, 1'b0, 1'b0, 16'h3C00, 3,  1'b0);
        run_op("neg_scale_s", 1'b1, 8'hFF, 15'h0000, 1'b0, 1'b0, 16'hC400, 3,  1'b0);
        run_op("negate",      1'b1, 8'h00, 15'h0000, 1'b0, 1'b0, 16'hC000, 3,  1'b0);
        run_op("round_up",    1'b0, 8'h00, 15'h7FFF, 1'b0, 1'b0, 16'h4400, 3,  1'b0);
        run_op("tie_even",    1'b0, 8'h00, 15'h0010, 1'b0, 1'b0, 16'h4000, 3,  1'b0);
        run_op("tie_odd",     1'b0, 8'h00, 15'h0030, 1'b0, 1'b0, 16'h4002, 3,  1'b0);
        run_op("general",     1'b0, 8'h0A, 15'h5555, 1'b0, 1'b0, 16'h6555, 4,  1'b0);
        run_op("neg_k_exp",   1'b1, 8'hF5, 15'h0000, 1'b0, 1'b0, 16'hE600, 4,  1'b0);
        run_op("sat_max",     1'b0, 8'h7F, 15'h1234, 1'b0, 1'b0, 16'h7FFF, 18, 1'b0);
        run_op("sat_min",     1'b0, 8'h80, 15'h1234, 1'b0, 1'b0, 16'h0001, 18, 1'b0);
        run_op("near_max",    1'b0, 8'h6F, 15'h0000, 1'b0, 1'b0, 16'h7FFF, 16, 1'b0);
        run_op("sat_min_neg", 1'b1, 8'h88, 15'h0000, 1'b0, 1'b0, 16'hFFFF, 17, 1'b0);
        run_op("near_min",    1'b0, 8'h90, 15'h0000, 1'b0, 1'b0, 16'h0001, 16, 1'b0);
        run_op("nar",         1'b0, 8'h00, 15'h0000, 1'b1, 1'b1, 16'h8000, 2,  1'b0);
        run_op("zero",        1'b1, 8'h12, 15'h4321, 1'b1, 1'b0, 16'h0000, 2,  1'b0);
        run_op("hold_start",  1'b0, 8'hF0, 15'h0000, 1'b0, 1'b0, 16'h1000, 4,  1'b1);

        // Abort a long operation mid-shift with an asynchronous reset.
        model(1'b0, 8'd100, 15'h1234, 1'b0, 1'b0, r_out, r_lat);
        @(negedge clk);
        enc.sign = 1'b0;
        enc.scale = 8'd100;
        enc.frac = 15'h1234;
        enc.start = 1'b1;
        @(posedge clk);
        #1;
        enc.start = 1'b0;
        exp_out = r_out;
        exp_lat = r_lat;
        arm_seq++;
        repeat (4) @(negedge clk);
        #2;
        abort_seq++;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", enc.busy, 0);
        check("rst_mid_done", enc.done, 0);
        check("rst_mid_out", enc.out, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("after_reset", 1'b0, 8'h00, 15'h0000, 1'b0, 1'b0, 16'h4000, 3,  1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
